// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
//   loader_state_t : loader FSM states
//   BYTES_PER_WORD : stream bytes per instruction word
//   LEN_BYTES      : bytes in the little-endian length header
//   CSUM_WIDTH     : width of the payload checksum
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    WRITE,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int CSUM_WIDTH     = 8;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (load restart)
//   shift_en   : a payload byte is accepted this cycle
//   byte_data  : the accepted byte
//   word       : word as it stands including the byte being accepted now
//   word_full  : the byte being accepted now completes the word
module word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] sh;
  logic [CW-1:0]         cnt;

  // Bytes enter at the top and move down, so after NB shifts byte 0
  // sits in [7:0]. The output already includes the incoming byte so the
  // loader can write the word on the same edge that accepts its last byte.
  assign word      = {byte_data, sh[DATA_WIDTH-1:8]};
  assign word_full = shift_en && (cnt == CW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sh  <= word;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader that fills instruction memory from a byte stream, verifies
// an 8-bit payload checksum and then releases the core from reset.
// Frame: LEN_LO, LEN_HI, 4*N payload bytes (little-endian words), checksum.
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse, begin or restart a load
//   byte_valid/byte_data/byte_ready : input byte stream handshake
//   we/waddr/wdata : instruction memory word write port
//   cpu_rst     : core reset, low only after a verified load
//   done/error  : sticky status until start or rst
//   word_count  : words written in current/last load
module instr_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam int WCW       = ADDR_WIDTH + 1;

  loader_state_t         state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [CSUM_WIDTH-1:0] sum;

  logic                  xfer;
  logic [15:0]           len_in;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  word_full;

  assign xfer     = byte_valid && byte_ready;
  assign len_in   = {byte_data, len_lo};
  // start takes priority over a coincident byte, so it is never consumed.
  assign shift_en = xfer && (state == PAYLOAD) && !start;

  word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .shift_en  (shift_en),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  // byte_ready is assigned alongside each transition so it always matches
  // the state being entered while remaining a plain flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      len_lo     <= '0;
      len        <= '0;
      sum        <= '0;
    end else if (start) begin
      state      <= LEN_LO;
      byte_ready <= 1'b1;
      we         <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      sum        <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        LEN_LO: if (xfer) begin
          len_lo <= byte_data;
          state  <= LEN_HI;
        end
        LEN_HI: if (xfer) begin
          len <= len_in;
          if (int'(len_in) > MAX_WORDS) begin
            state      <= ERR;
            byte_ready <= 1'b0;
            error      <= 1'b1;
          end else if (len_in == 16'd0) begin
            state <= CHECK;
          end else begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: if (xfer) begin
          sum <= sum + byte_data;
          if (word_full) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            we         <= 1'b1;
            waddr      <= word_count[ADDR_WIDTH-1:0];
            wdata      <= asm_word;
            word_count <= word_count + WCW'(1);
          end
        end
        // word_count was bumped on entry, so it already equals index+1.
        WRITE: begin
          byte_ready <= 1'b1;
          state      <= (32'(word_count) == 32'(len)) ? CHECK : PAYLOAD;
        end
        CHECK: if (xfer) begin
          byte_ready <= 1'b0;
          if (byte_data == sum) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        default: ;  // IDLE, DONE, ERR hold until start/rst
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  // Monitor: every write pulse is popped against the scoreboard.
  always @(negedge clk) begin
    if (we) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%08h, none expected", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (waddr !== e.addr || wdata !== e.data) begin
          errors++;
          $display("FAIL write got addr=%0d data=%08h expected addr=%0d data=%08h",
                   waddr, wdata, e.addr, e.data);
        end
      end
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write got %b expected 0", byte_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Presents a byte from a negedge and returns just after the accepting edge.
  // byte_valid stays high afterwards so back-to-back calls hold it continuously.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout byte %02h never accepted", b);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int maxgap);
    foreach (fr[i]) send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    chk("start_to_ready", {31'b0, byte_ready}, 32'd1);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e,
                            input logic cr, input logic [10:0] wc);
    @(negedge clk);
    byte_valid = 1'b0;
    chk({tag, "_done"}, {31'b0, done}, {31'b0, d});
    chk({tag, "_error"}, {31'b0, error}, {31'b0, e});
    chk({tag, "_cpu_rst"}, {31'b0, cpu_rst}, {31'b0, cr});
    chk({tag, "_word_count"}, {21'b0, word_count}, {21'b0, wc});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
    chk({tag, "_we"}, {31'b0, we}, 32'd0);
    chk({tag, "_waddr"}, {22'b0, waddr}, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    chk({tag, "_word_count"}, {21'b0, word_count}, 32'd0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_writes_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  logic [7:0] frame1[$]  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
  logic [7:0] frame1b[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00, 8'hE1};
  logic [7:0] frame0[$]  = '{8'h00, 8'h00, 8'h00};
  logic [7:0] frame_big[$] = '{8'h01, 8'h04};

  task automatic push_frame1();
    push_wr(10'd0, 32'h00100513);
    push_wr(10'd1, 32'h00200593);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // 1: good two-word load, byte_valid held continuously
    pulse_start();
    push_frame1();
    send_frame(frame1, 0);
    chk_status("t1", 1'b1, 1'b0, 1'b0, 11'd2);
    chk_drained("t1");

    // 2: bad checksum
    pulse_start();
    push_frame1();
    send_frame(frame1b, 0);
    chk_status("t2", 1'b0, 1'b1, 1'b1, 11'd2);
    chk_drained("t2");

    // 3: empty image
    pulse_start();
    send_frame(frame0, 0);
    chk_status("t3", 1'b1, 1'b0, 1'b0, 11'd0);
    chk_drained("t3");

    // 4: length above capacity
    pulse_start();
    send_frame(frame_big, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("t4_error", {31'b0, error}, 32'd1);
    chk("t4_ready", {31'b0, byte_ready}, 32'd0);
    chk("t4_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_ready_later", {31'b0, byte_ready}, 32'd0);
    chk_drained("t4");

    // 5: same image with random source gaps
    pulse_start();
    push_frame1();
    send_frame(frame1, 3);
    chk_status("t5", 1'b1, 1'b0, 1'b0, 11'd2);
    chk_drained("t5");

    // 6a: rst after 5 payload bytes
    pulse_start();
    push_wr(10'd0, 32'h00100513);
    for (int i = 0; i < 7; i++) send_byte(frame1[i], 0);
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    chk_drained("t6_rst");
    pulse_start();
    push_frame1();
    send_frame(frame1, 0);
    chk_status("t6a", 1'b1, 1'b0, 1'b0, 11'd2);
    chk_drained("t6a");

    // 6b: start mid-payload, coincident with an offered byte
    pulse_start();
    push_wr(10'd0, 32'h00100513);
    for (int i = 0; i < 8; i++) send_byte(frame1[i], 0);
    pulse_start();
    chk("t6b_word_count_clr", {21'b0, word_count}, 32'd0);
    push_frame1();
    send_frame(frame1, 0);
    chk_status("t6b", 1'b1, 1'b0, 1'b0, 11'd2);
    chk_drained("t6b");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
